// File: rtl/vecmac_job_sched.sv
// Two-client round-robin job scheduler that streams packed int8 operand words
// from a shared memory into the vector MAC and returns its sum (or a timeout).
module vecmac_job_sched #(
  parameter int ELEMS   = 1000,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W-1:0] base0_i,
  input  logic [ADDR_W-1:0] base1_i,
  output logic [1:0]        gnt_o,
  output logic              busy_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [31:0]       res_sum_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [31:0]       rd_data_a_i,
  input  logic [31:0]       rd_data_b_i,
  output logic              mac_vec_valid_o,
  output logic [31:0]       mac_vec_a_o,
  output logic [31:0]       mac_vec_b_o,
  input  logic              mac_result_valid_i,
  input  logic [31:0]       mac_result_sum_i
);

  localparam int BEATS = (ELEMS + LANES - 1) / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        own_q, own_d;
  logic              pref_q, pref_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     to_q, to_d;
  logic [31:0]       sum_q, sum_d;
  logic              err_q, err_d;
  logic              vld_q;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    pref_d  = pref_q;
    base_d  = base_q;
    beat_d  = beat_q;
    to_d    = to_q;
    sum_d   = sum_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          // Preferred client wins if it is asking; otherwise the other one must be.
          if (req_i[pref_q]) own_d = pref_q ? 2'b10 : 2'b01;
          else               own_d = pref_q ? 2'b01 : 2'b10;
          base_d  = own_d[1] ? base1_i : base0_i;
          beat_d  = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == BW'(BEATS - 1)) begin
          to_d    = '0;
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        to_d = to_q + 1'b1;
        if (mac_result_valid_i) begin
          sum_d   = mac_result_sum_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          sum_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        pref_d  = own_q[0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      own_q   <= '0;
      pref_q  <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
      to_q    <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      pref_q  <= pref_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      vld_q   <= rd_en_o;
    end
  end

  // Memory returns data one cycle after the strobe, so valid is the strobe delayed.
  assign rd_en_o         = (state_q == STREAM);
  assign rd_addr_o       = base_q + ADDR_W'(beat_q);
  assign mac_vec_valid_o = vld_q;
  assign mac_vec_a_o     = rd_data_a_i;
  assign mac_vec_b_o     = rd_data_b_i;
  assign gnt_o           = (state_q == STREAM || state_q == WAIT_RES) ? own_q : 2'b00;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE) ? own_q : 2'b00;
  assign err_o           = err_q;
  assign res_sum_o       = sum_q;

endmodule

// File: tb/tb_vecmac_job_sched.sv
// Bench for vecmac_job_sched: operand memory and a latency-controlled MAC stand-in,
// with expected sums computed element by element from the operand memory.
module tb_vecmac_job_sched;

  localparam int ELEMS   = 8;
  localparam int LANES   = 4;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 64;
  localparam int BEATS   = (ELEMS + LANES - 1) / LANES;
  localparam int MEMSZ   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstN;
  logic [1:0]        req;
  logic [ADDR_W-1:0] base0, base1;
  logic [1:0]        gnt, done;
  logic              busy, err;
  logic [31:0]       resSum;
  logic              rdEn;
  logic [ADDR_W-1:0] rdAddr;
  logic [31:0]       rdDataA, rdDataB;
  logic              macVecValid;
  logic [31:0]       macVecA, macVecB;
  logic              macResValid;
  logic [31:0]       macResSum;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;

  logic [31:0] memA [MEMSZ];
  logic [31:0] memB [MEMSZ];

  logic [ADDR_W-1:0] addrQ [$];
  int lastRd = 0;
  int vvCnt = 0;

  int macLatency = 0;
  bit macRespond = 1'b1;
  bit macFixedEn = 1'b0;
  logic [31:0] macFixed = 32'h0;
  int macAcc, macBeats, macDelay;
  logic [31:0] macSumLatched;

  vecmac_job_sched #(.ELEMS(ELEMS), .LANES(LANES), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rstN), .req_i(req), .base0_i(base0), .base1_i(base1),
    .gnt_o(gnt), .busy_o(busy), .done_o(done), .err_o(err), .res_sum_o(resSum),
    .rd_en_o(rdEn), .rd_addr_o(rdAddr), .rd_data_a_i(rdDataA), .rd_data_b_i(rdDataB),
    .mac_vec_valid_o(macVecValid), .mac_vec_a_o(macVecA), .mac_vec_b_o(macVecB),
    .mac_result_valid_i(macResValid), .mac_result_sum_i(macResSum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Operand memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rdEn) begin
      rdDataA <= memA[rdAddr];
      rdDataB <= memB[rdAddr];
    end
  end

  function automatic int beatDot(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    logic signed [7:0] x, y;
    for (int l = 0; l < 4; l++) begin
      x = a[8*l +: 8];
      y = b[8*l +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  // Reference dot product, walked element by element over the wrapped address space.
  function automatic int refDot(input logic [ADDR_W-1:0] base);
    int s = 0;
    int addr, lane;
    logic signed [7:0] x, y;
    for (int e = 0; e < ELEMS; e++) begin
      addr = (int'(base) + e / LANES) % MEMSZ;
      lane = e % LANES;
      x = memA[addr][8*lane +: 8];
      y = memB[addr][8*lane +: 8];
      s += int'(x) * int'(y);
    end
    return s;
  endfunction

  // MAC stand-in: accumulates BEATS valid beats, then answers after macLatency cycles.
  always @(posedge clk) begin
    macResValid <= 1'b0;
    if (!rstN) begin
      macAcc   <= 0;
      macBeats <= 0;
      macDelay <= -1;
    end else begin
      if (macVecValid) begin
        if (macBeats == BEATS - 1) begin
          macSumLatched <= macAcc + beatDot(macVecA, macVecB);
          macAcc   <= 0;
          macBeats <= 0;
          macDelay <= macLatency;
        end else begin
          macAcc   <= macAcc + beatDot(macVecA, macVecB);
          macBeats <= macBeats + 1;
        end
      end
      if (macDelay == 0) begin
        macResValid <= macRespond;
        macResSum   <= macFixedEn ? macFixed : macSumLatched;
        macDelay    <= -1;
      end else if (macDelay > 0) begin
        macDelay <= macDelay - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rstN && rdEn) begin
      addrQ.push_back(rdAddr);
      lastRd = cycleCnt;
    end
    if (rstN && macVecValid) vvCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input int maxCyc, output logic [1:0] d, output int cyc);
    d = 2'b00;
    cyc = -1;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        d = done;
        cyc = cycleCnt;
        break;
      end
    end
  endtask

  task automatic waitGrant(input int maxCyc, output logic [1:0] g, output int zeros);
    g = 2'b00;
    zeros = 0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        g = gnt;
        break;
      end
      zeros++;
    end
  endtask

  // One complete job for a single client, checked end to end.
  task automatic applyStimulus(input logic [1:0] who, input logic [ADDR_W-1:0] base,
                               input int lat, input bit respond, input bit fixedEn);
    logic [1:0] d;
    int cyc;
    bit accept;
    @(negedge clk);
    if (who[1]) base1 = base; else base0 = base;
    macLatency = lat;
    macRespond = respond;
    macFixedEn = fixedEn;
    macFixed   = 32'h0000_1234;
    addrQ.delete();
    vvCnt = 0;
    req = who;
    waitDone(300, d, cyc);
    req = 2'b00;
    accept = respond && (lat <= TIMEOUT - 3);
    checkOutput("job_done", d, who);
    checkOutput("job_err", err, accept ? 32'd0 : 32'd1);
    checkOutput("job_sum", resSum, !accept ? 32'd0 : (fixedEn ? 32'h1234 : refDot(base)));
    checkOutput("job_done_offset", cyc - lastRd, accept ? lat + 4 : TIMEOUT + 1);
    checkOutput("job_beats", addrQ.size(), BEATS);
    checkOutput("job_valid_beats", vvCnt, BEATS);
    for (int k = 0; k < addrQ.size() && k < BEATS; k++)
      checkOutput($sformatf("job_addr%0d", k), addrQ[k], (int'(base) + k) % MEMSZ);
    @(negedge clk);
    checkOutput("job_done_pulse", done, 2'b00);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [1:0] g, d, expOwn;
    int zeros, cyc, gapPrev;
    logic [ADDR_W-1:0] savedBase;

    for (int i = 0; i < MEMSZ; i++) begin
      memA[i] = $urandom;
      memB[i] = $urandom;
    end
    rstN = 1'b0;
    req = 2'b00;
    base0 = '0;
    base1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 2'b00);
    checkOutput("rst_rd_en", rdEn, 1'b0);
    checkOutput("rst_vec_valid", macVecValid, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_sum", resSum, 32'h0);
    rstN = 1'b1;

    applyStimulus(2'b01, 10'h010, 3, 1'b1, 1'b1);
    applyStimulus(2'b10, 10'h3FF, 5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus((i % 2) ? 2'b10 : 2'b01, ADDR_W'($urandom), $urandom_range(0, 20), 1'b1, 1'b0);

    applyStimulus(2'b01, ADDR_W'($urandom), 0, 1'b0, 1'b0);
    applyStimulus(2'b10, ADDR_W'($urandom), 2, 1'b1, 1'b0);
    applyStimulus(2'b01, ADDR_W'($urandom), TIMEOUT - 3, 1'b1, 1'b0);
    applyStimulus(2'b10, ADDR_W'($urandom), TIMEOUT - 2, 1'b1, 1'b0);

    // Both clients held: grants must alternate with two idle-grant cycles between jobs.
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    base0 = ADDR_W'($urandom);
    base1 = ADDR_W'($urandom);
    macRespond = 1'b1;
    macFixedEn = 1'b0;
    macLatency = $urandom_range(0, 20);
    req = 2'b11;
    gapPrev = 0;
    for (int i = 0; i < 4; i++) begin
      expOwn = (i % 2) ? 2'b10 : 2'b01;
      waitGrant(50, g, zeros);
      checkOutput("alt_gnt", g, expOwn);
      if (i > 0) checkOutput("alt_gap", gapPrev + zeros, 2);
      waitDone(200, d, cyc);
      checkOutput("alt_done", d, expOwn);
      checkOutput("alt_sum", resSum, refDot(expOwn[1] ? base1 : base0));
      gapPrev = (gnt === 2'b00) ? 1 : 0;
    end
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Leave client 1 preferred, then reset in the middle of its stream.
    applyStimulus(2'b01, ADDR_W'($urandom), 4, 1'b1, 1'b0);
    base0 = ADDR_W'($urandom);
    base1 = ADDR_W'($urandom);
    req = 2'b11;
    waitGrant(20, g, zeros);
    checkOutput("pre_rst_gnt", g, 2'b10);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rd_en", rdEn, 1'b0);
    checkOutput("mid_rst_vec_valid", macVecValid, 1'b0);
    checkOutput("mid_rst_gnt", gnt, 2'b00);
    checkOutput("mid_rst_done", done, 2'b00);
    checkOutput("mid_rst_busy", busy, 1'b0);
    rstN = 1'b1;
    waitGrant(20, g, zeros);
    checkOutput("post_rst_gnt", g, 2'b01);
    savedBase = base0;
    base0 = ~base0;
    waitDone(200, d, cyc);
    req = 2'b00;
    checkOutput("post_rst_done", d, 2'b01);
    checkOutput("post_rst_sum", resSum, refDot(savedBase));
    checkOutput("post_rst_err", err, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vecmac_job_sched.md
Name: vecmac_job_sched

Overview:
- Two-requester job scheduler in front of the vector MAC top (`vector_mac_top_param`).
- Arbitrates dot-product jobs round-robin between two clients.
- Streams each job's packed int8 operand words from a shared operand memory into the MAC.
- Waits for the MAC's final sum, then returns it to the granted client with a done pulse; a timeout covers a missing result.

Parameters:
- ELEMS, 1000: elements per vector. Must equal the MAC's ELEMS.
- LANES, 4: int8 lanes per 32-bit word. Must equal the MAC's ACTIVE_LANES; legal values 1 or 4.
- ADDR_W, 10: operand memory word-address width.
- TIMEOUT, 64: maximum cycles allowed in WAIT_RES before the job aborts with an error.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  2  per-client job request; level, held until that client's done.
- base0  in  ADDR_W  client 0 operand start address; sampled at grant.
- base1  in  ADDR_W  client 1 operand start address; sampled at grant.
- gnt  out  2  one-hot owner of the current job; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- done  out  2  one-cycle completion pulse to the owning client.
- err  out  1  valid with done; 1 means the job timed out.
- res_sum  out  32  job result; valid with done.
- rd_en  out  1  operand memory read strobe.
- rd_addr  out  ADDR_W  operand memory read address.
- rd_data_a  in  32  packed A word; valid 1 cycle after rd_en.
- rd_data_b  in  32  packed B word; valid 1 cycle after rd_en.
- mac_vec_valid  out  1  to MAC vec_valid.
- mac_vec_a  out  32  to MAC vec_a.
- mac_vec_b  out  32  to MAC vec_b.
- mac_result_valid  in  1  from MAC result_valid.
- mac_result_sum  in  32  from MAC result_sum.

Behaviour:
- BEATS = ceil(ELEMS/LANES), computed at elaboration (250 with defaults). Beat counter width is clog2(BEATS+1).
- Reset (rst_n=0 at an edge): state←IDLE; gnt, done, err, rd_en, mac_vec_valid ←0; res_sum←0; beat counter and timeout counter ←0; RR pointer←client 0 preferred.
  - Applies mid-job too; the in-flight job is dropped with no done.
- FSM states: IDLE, STREAM, WAIT_RES, DONE.
- IDLE:
  - If req≠0 at edge t, pick a winner: the preferred client if it is requesting, else the other.
  - At that edge: gnt←winner, latch the winner's base into the address register, beat←0, go to STREAM.
  - req=0: stay in IDLE.
- STREAM:
  - rd_en=1 and rd_addr=base+beat (mod 2^ADDR_W) in each of cycles t+1..t+BEATS; beat increments each cycle.
  - After issuing beat BEATS-1, go to WAIT_RES.
- MAC drive:
  - mac_vec_valid is rd_en registered by one cycle.
  - mac_vec_a/b pass rd_data_a/b through combinationally; they are don't-care when mac_vec_valid=0.
  - Exactly BEATS valid beats per job, contiguous, no bubbles.
- WAIT_RES:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - mac_result_valid=1 → res_sum←mac_result_sum, err←0, go to DONE.
  - Else if counter reaches TIMEOUT-1 → res_sum←0, err←1, go to DONE.
  - If result and timeout occur in the same cycle, the result wins (err=0).
- DONE (one cycle):
  - done[owner]=1.
  - RR pointer←the other client.
  - gnt←0, go to IDLE.
  - res_sum and err hold until the next DONE.
- mac_result_valid outside WAIT_RES is ignored.
- A req drop mid-job does not abort the job; done still pulses.
- base changes after grant have no effect on the current job.
- Minimum gap between jobs: DONE→IDLE→grant, i.e. 2 cycles with gnt=0 between consecutive grants.

Test Plan:
- ELEMS=8, LANES=4, base0=0x010, req=01:
  - rd_addr 0x010, 0x011 on two consecutive cycles; mac_vec_valid high for exactly 2 cycles.
  - Model MAC returns 0x0000_1234 → done=01, res_sum=0x1234, err=0.
- req=11 right after reset:
  - First grant 01, next grant 10.
  - With both held, the grant sequence alternates 01,10,01,10.
  - No overlap of gnt and busy gaps.
- Single job, MAC never asserts mac_result_valid (TIMEOUT=64):
  - done pulses exactly 64 cycles after WAIT_RES entry with err=1, res_sum=0.
  - The next job runs normally.
- base1=0x3FF, ADDR_W=10, ELEMS=8: rd_addr sequence 0x3FF, 0x000 (wrap).
- rst_n=0 for one cycle in the middle of STREAM:
  - Next cycle rd_en=0, mac_vec_valid=0, gnt=0, no done.
  - With req=11 held, re-arbitration grants client 0.
- mac_result_valid arriving on the timeout cycle: done with err=0 and the MAC sum captured.
